// File: rtl/adc_sample_ctrl.sv
// adc_sample_ctrl: periodic CNV/SCLK/SDO sequencer for a 16-bit serial current-sense ADC.
// Build option ADC_AVG4_EN: deliver one averaged sample per four conversion frames.
module adc_sample_ctrl #(
  parameter int CLK_DIV     = 4,
  parameter int CONV_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        clear_fail,
  input  logic [15:0] sample_period,
  input  logic        adc_sdo,
  output logic        adc_cnv,
  output logic        adc_sclk,
  output logic [15:0] adc_data,
  output logic        adc_data_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [CV_W-1:0] CV_LAST = CV_W'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t          state, state_next;
  logic [15:0]     period_cnt, period_q, eff_period;
  logic            counting, frame_req, wrap, overrun_evt;
  logic [CV_W-1:0] conv_cnt, conv_cnt_next;
  logic [PH_W-1:0] ph_cnt, ph_cnt_next;
  logic [4:0]      bit_cnt, bit_cnt_next;
  logic            sclk_next, sample_bit;
  logic [15:0]     shreg;

  assign counting    = enable && (sample_period != 16'd0);
  assign frame_req   = counting && (period_cnt == 16'd0);
  assign overrun_evt = frame_req && (state != IDLE);

  // Latched period can still be zero on the very first counting cycle; fall back to the live value.
  assign eff_period = (period_q == 16'd0) ? sample_period : period_q;
  assign wrap       = ({1'b0, period_cnt} + 17'd1) >= {1'b0, eff_period};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period_cnt <= 16'd0;
      period_q   <= 16'd0;
    end else if (!counting || wrap) begin
      period_cnt <= 16'd0;
      period_q   <= sample_period;
    end else begin
      period_cnt <= period_cnt + 16'd1;
    end
  end

  always_comb begin
    state_next    = state;
    conv_cnt_next = '0;
    ph_cnt_next   = '0;
    bit_cnt_next  = '0;
    sclk_next     = 1'b0;
    sample_bit    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_req) state_next = CONV;
      end
      CONV: begin
        if (conv_cnt == CV_LAST) state_next = SHIFT;
        else conv_cnt_next = conv_cnt + CV_W'(1);
      end
      SHIFT: begin
        sclk_next    = adc_sclk;
        bit_cnt_next = bit_cnt;
        if (ph_cnt != PH_LAST) begin
          ph_cnt_next = ph_cnt + PH_W'(1);
        end else if (!adc_sclk) begin
          sclk_next  = 1'b1;
          sample_bit = 1'b1;
        end else begin
          sclk_next    = 1'b0;
          bit_cnt_next = bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Link outputs are registered from the next state so nothing reaches a pin combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      conv_cnt <= '0;
      ph_cnt   <= '0;
      bit_cnt  <= 5'd0;
      adc_sclk <= 1'b0;
      adc_cnv  <= 1'b0;
      busy     <= 1'b0;
      shreg    <= 16'd0;
    end else begin
      state    <= state_next;
      conv_cnt <= conv_cnt_next;
      ph_cnt   <= ph_cnt_next;
      bit_cnt  <= bit_cnt_next;
      adc_sclk <= sclk_next;
      adc_cnv  <= (state_next == CONV);
      busy     <= (state_next != IDLE);
      if (sample_bit) shreg <= {shreg[14:0], adc_sdo};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun <= 1'b0;
    end else if (overrun_evt) begin
      overrun <= 1'b1;
    end else if (clear_fail) begin
      overrun <= 1'b0;
    end
  end

`ifdef ADC_AVG4_EN
  logic [17:0] acc, acc_sum;
  logic [1:0]  avg_cnt;

  assign acc_sum = acc + {2'b00, shreg};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      adc_data       <= 16'd0;
      adc_data_valid <= 1'b0;
      acc            <= 18'd0;
      avg_cnt        <= 2'd0;
    end else begin
      adc_data_valid <= 1'b0;
      if (!enable) begin
        acc     <= 18'd0;
        avg_cnt <= 2'd0;
      end else if (state == DONE) begin
        if (avg_cnt == 2'd3) begin
          adc_data       <= acc_sum[17:2];
          adc_data_valid <= 1'b1;
          acc            <= 18'd0;
          avg_cnt        <= 2'd0;
        end else begin
          acc     <= acc_sum;
          avg_cnt <= avg_cnt + 2'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      adc_data       <= 16'd0;
      adc_data_valid <= 1'b0;
    end else begin
      adc_data_valid <= (state == DONE);
      if (state == DONE) adc_data <= shreg;
    end
  end
`endif

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// tb_adc_sample_ctrl: table vectors, randomized runs and corner sequences for adc_sample_ctrl,
// checked against a frame-level timing model and a behavioural serial ADC.
module tb_adc_sample_ctrl;

  localparam int CLK_DIV     = 2;
  localparam int CONV_CYCLES = 10;
  localparam int LATENCY     = CONV_CYCLES + 2 * CLK_DIV * 16 + 1;
  localparam int MIN_GAP     = CONV_CYCLES + 32 * CLK_DIV + 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        clear_fail = 1'b0;
  logic        adc_sdo = 1'b0;
  logic [15:0] sample_period = 16'd0;
  logic        adc_cnv, adc_sclk, adc_data_valid, busy, overrun;
  logic [15:0] adc_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int          cnv_q[$];
  int          valid_t_q[$];
  logic [15:0] valid_d_q[$];
  logic [15:0] word_q[$];
  logic [15:0] def_word = 16'd0;
  logic [15:0] cur_word = 16'd0;
  int          bitk = 0;
  logic        prev_cnv = 1'b0;
  logic        prev_sclk = 1'b0;

  int   exp_starts[$];
  logic exp_ovr;

  typedef struct {
    logic [15:0] period;
    logic [15:0] word;
    int          cycles;
    int          exp_valids;
    logic        exp_ovr;
  } vec_t;

  vec_t tbl[4];

  adc_sample_ctrl #(.CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES)) dut (
    .clk(clk),
    .rstn(rstn),
    .enable(enable),
    .clear_fail(clear_fail),
    .sample_period(sample_period),
    .adc_sdo(adc_sdo),
    .adc_cnv(adc_cnv),
    .adc_sclk(adc_sclk),
    .adc_data(adc_data),
    .adc_data_valid(adc_data_valid),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial ADC model: MSB presented at CNV rise, next bit after every SCLK rise; also logs events.
  always @(negedge clk) begin
    if (adc_cnv && !prev_cnv) begin
      cnv_q.push_back(cyc);
      if (word_q.size() > 0) cur_word = word_q.pop_front();
      else cur_word = def_word;
      bitk = 0;
    end
    if (adc_sclk && !prev_sclk) bitk++;
    if (adc_data_valid) begin
      valid_t_q.push_back(cyc);
      valid_d_q.push_back(adc_data);
    end
    prev_cnv  = adc_cnv;
    prev_sclk = adc_sclk;
    adc_sdo   = (bitk < 16) ? cur_word[15 - bitk] : 1'b0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rstn = 1'b0;
    enable = 1'b0;
    clear_fail = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    cnv_q.delete();
    valid_t_q.delete();
    valid_d_q.delete();
    word_q.delete();
  endtask

  task automatic applyStimulus(input logic [15:0] period, input logic [15:0] word, input int cycles,
                               output int e0, output int last);
    doReset();
    def_word = word;
    sample_period = period;
    @(negedge clk);
    enable = 1'b1;
    e0 = cyc + 1;
    repeat (cycles) @(negedge clk);
    #1;
    last = cyc;
  endtask

  // Requests every p cycles from the first enabled edge; a request is taken only if the
  // previous frame has fully returned to idle, otherwise it is lost and flags overrun.
  task automatic modelFrames(input int e0, input int p, input int last);
    int prev = -100000;
    exp_starts.delete();
    exp_ovr = 1'b0;
    if (p > 0) begin
      for (int r = e0; r <= last; r += p) begin
        if (r - prev >= MIN_GAP) begin
          exp_starts.push_back(r);
          prev = r;
        end else begin
          exp_ovr = 1'b1;
        end
      end
    end
  endtask

  task automatic compareRun(input int last, input logic [15:0] word);
    int nv = 0;
    foreach (exp_starts[i]) if (exp_starts[i] + LATENCY <= last) nv++;
    checkOutput("cnv_count", cnv_q.size(), exp_starts.size());
    for (int i = 0; i < exp_starts.size() && i < cnv_q.size(); i++)
      checkOutput("cnv_time", cnv_q[i], exp_starts[i]);
    checkOutput("valid_count", valid_t_q.size(), nv);
    for (int i = 0; i < nv && i < valid_t_q.size(); i++) begin
      checkOutput("valid_time", valid_t_q[i], exp_starts[i] + LATENCY);
      checkOutput("valid_data", valid_d_q[i], word);
    end
    checkOutput("overrun", overrun, exp_ovr);
  endtask

  initial begin
    int e0, e1, last, n_active;
    logic [15:0] p, w;

    tbl[0] = '{16'd100, 16'hA5C3, 400, 4, 1'b0};
    tbl[1] = '{16'd50,  16'hA5C3, 400, 4, 1'b1};
    tbl[2] = '{16'd76,  16'h8001, 400, 5, 1'b0};
    tbl[3] = '{16'd75,  16'h7FFE, 400, 3, 1'b1};

    doReset();
    #1;
    checkOutput("reset_cnv", adc_cnv, 0);
    checkOutput("reset_sclk", adc_sclk, 0);
    checkOutput("reset_data", adc_data, 0);
    checkOutput("reset_valid", adc_data_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_overrun", overrun, 0);

`ifdef ADC_AVG4_EN
    doReset();
    sample_period = 16'd100;
    word_q.push_back(16'h1000);
    word_q.push_back(16'h2000);
    word_q.push_back(16'h3000);
    word_q.push_back(16'h4000);
    @(negedge clk);
    enable = 1'b1;
    e0 = cyc + 1;
    repeat (400) @(negedge clk);
    #1;
    checkOutput("avg_valid_count", valid_t_q.size(), 1);
    if (valid_t_q.size() > 0) begin
      checkOutput("avg_valid_time", valid_t_q[0], e0 + 300 + LATENCY);
      checkOutput("avg_valid_data", valid_d_q[0], 16'h2800);
    end
`else
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].period, tbl[i].word, tbl[i].cycles, e0, last);
      modelFrames(e0, tbl[i].period, last);
      checkOutput("tbl_valid_count", valid_t_q.size(), tbl[i].exp_valids);
      checkOutput("tbl_overrun", overrun, tbl[i].exp_ovr);
      compareRun(last, tbl[i].word);
    end

    for (int k = 0; k < 6; k++) begin
      p = 16'($urandom_range(40, 160));
      w = 16'($urandom);
      applyStimulus(p, w, 350, e0, last);
      modelFrames(e0, p, last);
      compareRun(last, w);
    end

    // Enable falls 20 cycles into a frame: that frame still delivers, nothing new starts.
    doReset();
    def_word = 16'h3C5A;
    sample_period = 16'd100;
    @(negedge clk);
    enable = 1'b1;
    e0 = cyc + 1;
    while (cyc < e0 + 19) @(negedge clk);
    enable = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    checkOutput("drop_cnv_count", cnv_q.size(), 1);
    checkOutput("drop_valid_count", valid_t_q.size(), 1);
    if (valid_t_q.size() > 0) begin
      checkOutput("drop_valid_time", valid_t_q[0], e0 + LATENCY);
      checkOutput("drop_valid_data", valid_d_q[0], 16'h3C5A);
    end
    checkOutput("drop_busy", busy, 0);
    @(negedge clk);
    enable = 1'b1;
    e1 = cyc + 1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reenable_cnv_count", cnv_q.size(), 2);
    if (cnv_q.size() > 1) checkOutput("reenable_cnv_time", cnv_q[1], e1);

    // Asynchronous reset in the middle of the second frame's shift phase.
    doReset();
    def_word = 16'h0F0F;
    sample_period = 16'd50;
    @(negedge clk);
    enable = 1'b1;
    e0 = cyc + 1;
    while (cyc < e0 + 130) @(negedge clk);
    checkOutput("pre_reset_data", adc_data, 16'h0F0F);
    checkOutput("pre_reset_overrun", overrun, 1);
    checkOutput("pre_reset_busy", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("midrst_cnv", adc_cnv, 0);
    checkOutput("midrst_sclk", adc_sclk, 0);
    checkOutput("midrst_data", adc_data, 0);
    checkOutput("midrst_valid", adc_data_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_overrun", overrun, 0);
    @(negedge clk);
    rstn = 1'b1;
    e1 = cyc + 1;
    cnv_q.delete();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("postrst_cnv_count", cnv_q.size(), 1);
    if (cnv_q.size() > 0) checkOutput("postrst_cnv_time", cnv_q[0], e1);

    // Sticky overrun: clear, re-arm, and a clear coinciding with a dropped request.
    doReset();
    def_word = 16'h1234;
    sample_period = 16'd50;
    @(negedge clk);
    enable = 1'b1;
    e0 = cyc + 1;
    while (cyc < e0 + 60) @(negedge clk);
    checkOutput("ovr_set", overrun, 1);
    clear_fail = 1'b1;
    @(negedge clk);
    clear_fail = 1'b0;
    @(negedge clk);
    checkOutput("ovr_cleared", overrun, 0);
    while (cyc < e0 + 149) @(negedge clk);
    checkOutput("ovr_before_drop", overrun, 0);
    clear_fail = 1'b1;
    @(negedge clk);
    clear_fail = 1'b0;
    checkOutput("ovr_set_wins", overrun, 1);

    // Zero period never requests a frame.
    doReset();
    sample_period = 16'd0;
    @(negedge clk);
    enable = 1'b1;
    n_active = 0;
    repeat (1000) begin
      @(negedge clk);
      if (adc_cnv || busy) n_active++;
    end
    checkOutput("p0_active_cycles", n_active, 0);
    checkOutput("p0_cnv_count", cnv_q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_sample_ctrl.md
# adc_sample_ctrl

Sequencer for the external 16-bit serial current-sense ADC. It issues periodic conversion starts, clocks the result out over a 3-wire CNV/SCLK/SDO link and presents each sample as `adc_data`/`adc_data_valid` to the current and pulse-rate checkers. It also flags overrun when the programmed sample period is shorter than one conversion frame.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in clk cycles, minimum 1.
- `CONV_CYCLES`, default 40: CNV high time in clk cycles, minimum 1.
- `clk`, input, 1: system clock.
- `rstn`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: run periodic sampling.
- `clear_fail`, input, 1: synchronous clear of sticky `overrun`.
- `sample_period`, input, 16: clk cycles between frame starts. 0 means no frames.
- `adc_sdo`, input, 1: ADC serial data, MSB first.
- `adc_cnv`, output, 1: conversion start, active high.
- `adc_sclk`, output, 1: serial clock, idles low.
- `adc_data`, output, 16: last completed sample.
- `adc_data_valid`, output, 1: one-cycle strobe on `adc_data` update.
- `busy`, output, 1: frame in progress (state ≠ IDLE).
- `overrun`, output, 1: sticky; a frame start was missed.

## Operation
- Reset values: `adc_cnv`=0, `adc_sclk`=0, `adc_data`=0, `adc_data_valid`=0, `busy`=0, `overrun`=0, period counter 0, state IDLE.
- Period counter, 16 bits:
  - Counts 0..`sample_period`-1 and wraps while `enable`=1 and `sample_period`≠0.
  - Otherwise it is held at 0.
  - `sample_period` is sampled at each wrap.
- Frame request: counter==0 while counting.
  - State IDLE: the frame starts.
  - Any other state: the request is dropped and `overrun` is set.
- FSM states:
  - IDLE: waits for a frame request.
  - CONV: `adc_cnv`=1 for `CONV_CYCLES` cycles, then goes to SHIFT.
  - SHIFT: `adc_cnv`=0. 16 SCLK periods run, each low for `CLK_DIV` cycles and then high for `CLK_DIV` cycles. `adc_sdo` is sampled into the shift register on the clk edge that drives `adc_sclk` high. After the 16th high phase `adc_sclk` returns low and the FSM goes to DONE.
  - DONE: loads `adc_data` from the shift register, pulses `adc_data_valid`, then goes to IDLE.
- `enable` falling mid-frame: the frame completes and delivers its data. No new frames start. On re-enable, a frame starts on the first counting cycle (counter==0).
- `clear_fail` and an overrun event in the same cycle: set wins.
- Bit counter is 5 bits. The SCLK phase counter is sized to `CLK_DIV`. No wrap-around inside a frame.

## Timing
- Frame start (CONV entry) to `adc_data_valid`: `CONV_CYCLES` + 2·`CLK_DIV`·16 + 1 cycles.
- Minimum overrun-free `sample_period` = `CONV_CYCLES` + 32·`CLK_DIV` + 2. The default is 170.
- `adc_sdo` must be stable for one clk cycle before each rising SCLK. The MSB must be valid when CNV falls.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `ADC_AVG4_EN` defined:
  - An 18-bit accumulator sums 4 consecutive frames.
  - Every 4th frame, `adc_data` = sum[17:2] and `adc_data_valid` pulses. Valid is suppressed on the other 3 frames.
  - The accumulator and frame count clear while `enable`=0.
- `ADC_AVG4_EN` undefined: every frame updates `adc_data` and pulses valid. No accumulator is present.

## Test plan
- `CLK_DIV`=2, `CONV_CYCLES`=10, `sample_period`=100, SDO model returns 0xA5C3 -> `adc_data`=0xA5C3. Valid pulses 75 cycles after each CNV rise and every 100 cycles, with `overrun`=0.
- Same setup with `sample_period`=50 -> alternate requests dropped and `overrun`=1. Valid every 100 cycles. `clear_fail` pulse -> `overrun`=0, then set again at the next dropped request.
- Drop `enable` at cycle 20 of a frame -> that frame's valid is still delivered, with no further CNV. Re-enable -> CNV rises 1 cycle after `enable`.
- Assert `rstn`=0 mid-SHIFT -> all outputs go to reset values immediately. After release, with `enable`=1, a fresh frame starts.
- `sample_period`=0 with `enable`=1 -> no CNV for 1000 cycles and `busy`=0.
- With `ADC_AVG4_EN`, samples 0x1000, 0x2000, 0x3000, 0x4000 -> a single valid with `adc_data`=0x2800.
